// File: rtl/led_pkg.sv
// Shared font table, scan FSM states and width helper for the LED scanner.
package led_pkg;

   localparam logic [6:0] SEG_OFF = 7'b111_1111;

   // Hex font, segments {A,B,C,D,E,F,G}, active-low.
   localparam logic [6:0] FONT_0 = 7'b000_0001;
   localparam logic [6:0] FONT_1 = 7'b100_1111;
   localparam logic [6:0] FONT_2 = 7'b001_0010;
   localparam logic [6:0] FONT_3 = 7'b000_0110;
   localparam logic [6:0] FONT_4 = 7'b100_1100;
   localparam logic [6:0] FONT_5 = 7'b010_0100;
   localparam logic [6:0] FONT_6 = 7'b010_0000;
   localparam logic [6:0] FONT_7 = 7'b000_1111;
   localparam logic [6:0] FONT_8 = 7'b000_0000;
   localparam logic [6:0] FONT_9 = 7'b000_0100;
   localparam logic [6:0] FONT_A = 7'b000_1000;
   localparam logic [6:0] FONT_B = 7'b110_0000;
   localparam logic [6:0] FONT_C = 7'b011_0001;
   localparam logic [6:0] FONT_D = 7'b100_0010;
   localparam logic [6:0] FONT_E = 7'b011_0000;
   localparam logic [6:0] FONT_F = 7'b011_1000;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_e;

   // Ceiling log2 for elaboration-time width calculation.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/multi_digit_led_scanner_seg_font.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg_font
   import led_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   // Font lookup.
   always_comb begin
      seg_o = SEG_OFF;
      case (nib_i)
         4'h0: seg_o = FONT_0;
         4'h1: seg_o = FONT_1;
         4'h2: seg_o = FONT_2;
         4'h3: seg_o = FONT_3;
         4'h4: seg_o = FONT_4;
         4'h5: seg_o = FONT_5;
         4'h6: seg_o = FONT_6;
         4'h7: seg_o = FONT_7;
         4'h8: seg_o = FONT_8;
         4'h9: seg_o = FONT_9;
         4'hA: seg_o = FONT_A;
         4'hB: seg_o = FONT_B;
         4'hC: seg_o = FONT_C;
         4'hD: seg_o = FONT_D;
         4'hE: seg_o = FONT_E;
         4'hF: seg_o = FONT_F;
         default: seg_o = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/multi_digit_led_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with dead-time,
// leading-zero blanking and frame-synchronous double buffering.
module multi_digit_led_scanner
   import led_pkg::*;
#(
   parameter int unsigned DIGITS       = 4,
   parameter int unsigned SLOT_CYCLES  = 16,
   parameter int unsigned BLANK_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     digit_en,
   input  logic                  lzb,
   input  logic                  load,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            LED,
   output logic                  dp_out,
   output logic                  frame_done
);

   localparam int unsigned CW = clog2(SLOT_CYCLES);
   localparam int unsigned IW = (DIGITS > 1) ? clog2(DIGITS) : 1;
   localparam int unsigned DW = 4 * DIGITS;

   // Reject illegal configurations at elaboration.
   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $fatal(1, "DIGITS must be in 1..8");
   end
   if (SLOT_CYCLES < 2) begin : g_bad_slot
      $fatal(1, "SLOT_CYCLES must be >= 2");
   end
   if (BLANK_CYCLES >= SLOT_CYCLES) begin : g_bad_blank
      $fatal(1, "BLANK_CYCLES must be < SLOT_CYCLES");
   end

   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   scan_state_e       state_q, state_d;
   logic [DW-1:0]     shadow_q, shadow_d, pend_q, pend_d;
   logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d, pend_dp_q, pend_dp_d;
   logic              pend_flag_q, pend_flag_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic [6:0]        led_q, led_d;
   logic              dp_out_q, dp_out_d;
   logic              frame_done_q, frame_done_d;

   logic              wrap_c, frame_end_c, in_blank_c, zero_run, visible_c;
   logic [DIGITS-1:0] lz_c, sel_an_c;
   logic [3:0]        sel_nib_c;
   logic              sel_dp_c, sel_en_c, sel_lz_c;
   logic [6:0]        font_seg_c;

   // Slot counter and digit index advance.
   always_comb begin
      wrap_c      = (cnt_q == CW'(SLOT_CYCLES - 1));
      cnt_d       = wrap_c ? '0 : cnt_q + CW'(1);
      idx_d       = idx_q;
      if (wrap_c) idx_d = (idx_q == '0) ? IW'(DIGITS - 1) : idx_q - IW'(1);
      frame_end_c = wrap_c && (idx_q == '0);
   end

   // Dead-time window at the start of each slot.
   if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank_c = 1'b0;
   end else begin : g_blank
      assign in_blank_c = (cnt_d < CW'(BLANK_CYCLES));
   end

   // Scan phase transitions.
   always_comb begin
      state_d = state_q;
      case (state_q)
         BLANK:   if (!in_blank_c) state_d = DRIVE;
         DRIVE:   if (in_blank_c)  state_d = BLANK;
         default: state_d = BLANK;
      endcase
   end

   // Pending capture and frame-boundary shadow transfer.
   always_comb begin
      pend_d      = pend_q;
      pend_dp_d   = pend_dp_q;
      pend_flag_d = pend_flag_q;
      shadow_d    = shadow_q;
      shadow_dp_d = shadow_dp_q;
      if (load) begin
         pend_d      = data;
         pend_dp_d   = dp;
         pend_flag_d = 1'b1;
      end
      if (frame_end_c) begin
         if (load) begin
            shadow_d    = data;
            shadow_dp_d = dp;
         end else if (pend_flag_q) begin
            shadow_d    = pend_q;
            shadow_dp_d = pend_dp_q;
         end
         pend_flag_d = 1'b0;
      end
   end

   // Leading-zero mask: digit i is blankable if nibbles DIGITS-1..i are zero.
   always_comb begin
      zero_run = 1'b1;
      lz_c     = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run & (shadow_d[4*i +: 4] == 4'h0);
         lz_c[i]  = zero_run & (i != 0);
      end
   end

   // Per-digit selection for the upcoming cycle.
   always_comb begin
      sel_nib_c = '0;
      sel_dp_c  = 1'b0;
      sel_en_c  = 1'b0;
      sel_lz_c  = 1'b0;
      sel_an_c  = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_d == IW'(i)) begin
            sel_nib_c   = shadow_d[4*i +: 4];
            sel_dp_c    = shadow_dp_d[i];
            sel_en_c    = digit_en[i];
            sel_lz_c    = lz_c[i];
            sel_an_c[i] = 1'b0;
         end
      end
   end

   seg_font u_font (
      .nib_i (sel_nib_c),
      .seg_o (font_seg_c)
   );

   // Next registered display outputs.
   always_comb begin
      visible_c    = sel_en_c & ~(lzb & sel_lz_c);
      an_d         = '1;
      led_d        = SEG_OFF;
      dp_out_d     = 1'b1;
      if (state_d == DRIVE && visible_c) begin
         an_d     = sel_an_c;
         led_d    = font_seg_c;
         dp_out_d = ~sel_dp_c;
      end
      frame_done_d = (cnt_d == CW'(SLOT_CYCLES - 1)) && (idx_d == '0);
   end

   // All state and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q        <= '0;
         idx_q        <= IW'(DIGITS - 1);
         state_q      <= BLANK;
         shadow_q     <= '0;
         shadow_dp_q  <= '0;
         pend_q       <= '0;
         pend_dp_q    <= '0;
         pend_flag_q  <= 1'b0;
         an_q         <= '1;
         led_q        <= SEG_OFF;
         dp_out_q     <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         state_q      <= state_d;
         shadow_q     <= shadow_d;
         shadow_dp_q  <= shadow_dp_d;
         pend_q       <= pend_d;
         pend_dp_q    <= pend_dp_d;
         pend_flag_q  <= pend_flag_d;
         an_q         <= an_d;
         led_q        <= led_d;
         dp_out_q     <= dp_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an         = an_q;
   assign LED        = led_q;
   assign dp_out     = dp_out_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_multi_digit_led_scanner.sv
// Bench for the LED scanner: a 4-digit instance under directed and random
// stimulus, plus a 1-digit, 2-cycle-slot, no-dead-time instance.
module tb_multi_digit_led_scanner;

   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic [15:0] data_a = '0;
   logic [3:0]  dp_a = '0, en_a = 4'hf;
   logic        lzb_a = 1'b0, load_a = 1'b0;
   logic [3:0]  an_a;
   logic [6:0]  led_a;
   logic        dpo_a, fd_a;

   logic [3:0]  data_b = '0;
   logic [0:0]  dp_b = '0, en_b = 1'b1;
   logic        lzb_b = 1'b0, load_b = 1'b0;
   logic [0:0]  an_b;
   logic [6:0]  led_b;
   logic        dpo_b, fd_b;

   int tests = 0;
   int fails = 0;

   logic [6:0] font_t [16] = '{7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110,
                               7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
                               7'b000_0000, 7'b000_0100, 7'b000_1000, 7'b110_0000,
                               7'b011_0001, 7'b100_0010, 7'b011_0000, 7'b011_1000};

   // Reference state: cycles since reset release, visible and pending buffers.
   int          ta, tb_, last_fd;
   logic [31:0] sha, penda, shb, pendb;
   logic [7:0]  shdpa, penddpa, shdpb, penddpb, en_pa, en_pb;
   logic        pfa, pfb, lzb_pa, lzb_pb;

   always #5 clk = ~clk;

   multi_digit_led_scanner #(.DIGITS(4), .SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut_a (
      .clk(clk), .reset(reset), .data(data_a), .dp(dp_a), .digit_en(en_a),
      .lzb(lzb_a), .load(load_a), .an(an_a), .LED(led_a), .dp_out(dpo_a),
      .frame_done(fd_a)
   );

   multi_digit_led_scanner #(.DIGITS(1), .SLOT_CYCLES(2), .BLANK_CYCLES(0)) dut_b (
      .clk(clk), .reset(reset), .data(data_b), .dp(dp_b), .digit_en(en_b),
      .lzb(lzb_b), .load(load_b), .an(an_b), .LED(led_b), .dp_out(dpo_b),
      .frame_done(fd_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h (tA=%0d)", tag, obs, exp, ta);
      end
   endtask

   // Display contents for cycle t from the scan timing rules: MSB-first slots,
   // dead-time at slot start, enable/leading-zero suppression.
   function automatic void model(input int D, input int S, input int B, input int t,
                                 input logic [31:0] sh, input logic [7:0] shdp,
                                 input logic [7:0] en, input logic lz,
                                 output logic [7:0] ean, output logic [6:0] eled,
                                 output logic edp, output logic efd);
      int pos, c, d;
      ean = 8'hff; eled = 7'h7f; edp = 1'b1; efd = 1'b0;
      if (t == 0) return;
      pos = t % (D * S);
      c   = pos % S;
      d   = D - 1 - pos / S;
      efd = (pos == D * S - 1);
      if (c < B || !en[d]) return;
      if (lz && d > 0 && (sh >> (4 * d)) == 32'd0) return;
      ean[d] = 1'b0;
      eled   = font_t[4'((sh >> (4 * d)) & 32'hf)];
      edp    = ~shdp[d];
   endfunction

   task automatic reset_models();
      ta = 0; tb_ = 0; last_fd = -1;
      sha = '0; penda = '0; shdpa = '0; penddpa = '0; pfa = 1'b0; en_pa = '0; lzb_pa = 1'b0;
      shb = '0; pendb = '0; shdpb = '0; penddpb = '0; pfb = 1'b0; en_pb = '0; lzb_pb = 1'b0;
   endtask

   task automatic check_all();
      logic [7:0] ean;
      logic [6:0] eled;
      logic       edp, efd;
      model(4, 8, 2, ta, sha, shdpa, en_pa, lzb_pa, ean, eled, edp, efd);
      check("A.an", 32'(an_a), 32'(ean[3:0]));
      check("A.LED", 32'(led_a), 32'(eled));
      check("A.dp_out", 32'(dpo_a), 32'(edp));
      check("A.frame_done", 32'(fd_a), 32'(efd));
      if (fd_a) begin
         if (last_fd >= 0) check("A.frame_period", 32'(ta - last_fd), 32'd32);
         last_fd = ta;
      end
      model(1, 2, 0, tb_, shb, shdpb, en_pb, lzb_pb, ean, eled, edp, efd);
      check("B.an", 32'(an_b), 32'(ean[0]));
      check("B.LED", 32'(led_b), 32'(eled));
      check("B.dp_out", 32'(dpo_b), 32'(edp));
      check("B.frame_done", 32'(fd_b), 32'(efd));
   endtask

   // One clock: fold this cycle's inputs into the reference, then compare.
   task automatic step();
      data_b = 4'($urandom);
      dp_b   = 1'($urandom);
      lzb_b  = 1'($urandom);
      load_b = 1'($urandom);
      if ((ta % 32) == 31) begin
         if (load_a) begin sha = 32'(data_a); shdpa = 8'(dp_a); end
         else if (pfa) begin sha = penda; shdpa = penddpa; end
         pfa = 1'b0;
      end else if (load_a) begin
         penda = 32'(data_a); penddpa = 8'(dp_a); pfa = 1'b1;
      end
      en_pa = 8'(en_a); lzb_pa = lzb_a;
      if ((tb_ % 2) == 1) begin
         if (load_b) begin shb = 32'(data_b); shdpb = 8'(dp_b); end
         else if (pfb) begin shb = pendb; shdpb = penddpb; end
         pfb = 1'b0;
      end else if (load_b) begin
         pendb = 32'(data_b); penddpb = 8'(dp_b); pfb = 1'b1;
      end
      en_pb = 8'(en_b); lzb_pb = lzb_b;
      @(posedge clk);
      @(negedge clk);
      ta++; tb_++;
      check_all();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic run_to(input int pos);
      for (int k = 0; k < 64; k++) begin
         if ((ta % 32) == pos) break;
         step();
      end
   endtask

   task automatic load_a_once(input logic [15:0] d, input logic [3:0] p);
      data_a = d; dp_a = p; load_a = 1'b1;
      step();
      load_a = 1'b0;
   endtask

   initial begin
      reset_models();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      check_all();

      // Basic display of 1234 after the first frame boundary.
      load_a_once(16'h1234, 4'h0);
      run_to(31);
      run(3);
      check("A.first_digit_an", 32'(an_a), 32'h7);
      check("A.first_digit_LED", 32'(led_a), 32'b100_1111);
      run(64);

      // Leading-zero blanking.
      lzb_a = 1'b1;
      load_a_once(16'h0070, 4'h0);
      run(64);
      load_a_once(16'h0000, 4'h0);
      run(64);
      lzb_a = 1'b0;
      run(32);

      // Mid-frame load must not tear the current frame.
      run_to(11);
      load_a_once(16'hABCD, 4'h0);
      run(64);
      run_to(4);
      check("A.hex_A", 32'(led_a), 32'b000_1000);

      // Digit enables and decimal points.
      en_a = 4'b1010;
      load_a_once(16'h5678, 4'b0011);
      run(64);

      // Asynchronous reset during a drive cycle of digit 1.
      run_to(20);
      check("A.pre_reset_an", 32'(an_a), 32'hd);
      #2 reset = 1'b0;
      #1;
      check("A.rst_an", 32'(an_a), 32'hf);
      check("A.rst_LED", 32'(led_a), 32'h7f);
      check("A.rst_dp_out", 32'(dpo_a), 32'h1);
      check("A.rst_frame_done", 32'(fd_a), 32'h0);
      check("B.rst_an", 32'(an_b), 32'h1);
      @(negedge clk);
      reset = 1'b1;
      reset_models();
      en_a = 4'hf; lzb_a = 1'b1; dp_a = '0;
      check_all();
      run(40);

      // Randomized traffic.
      for (int k = 0; k < 800; k++) begin
         if ((k % 50) == 0) begin
            en_a  = $urandom_range(0, 1) ? 4'hf : 4'($urandom);
            lzb_a = 1'($urandom);
         end
         data_a = 16'($urandom) >> $urandom_range(0, 16);
         dp_a   = 4'($urandom);
         load_a = ($urandom_range(0, 7) == 0);
         step();
      end
      load_a = 1'b0;
      run(8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
